// File: rtl/rx_link_ctrl_pkg.sv
// rx_link_ctrl shared definitions: state encodings and raw phase limit.
// Also used by the status register map.
package rx_link_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_RX_RST    = 3'd1,
    ST_WAIT_SYNC = 3'd2,
    ST_SCAN      = 3'd3,
    ST_LOCKED    = 3'd4
  } link_st_e;

  localparam logic [3:0] PHASE_MAX = 4'd9;

  function automatic logic [3:0] next_phase(
    input logic [3:0] p
  );
    return (p == PHASE_MAX) ? 4'd0 : p + 4'd1;
  endfunction

endpackage

// File: rtl/rx_link_ctrl_err_window.sv
// Decoder error supervision: fixed window plus error counter.
// An error on the window's last cycle starts the next window's count.
module rx_link_err_window #(
  parameter int unsigned WINDOW    = 1024,
  parameter int unsigned THRESHOLD = 8
) (
  input  logic WCLK,
  input  logic RESET,
  input  logic clear,
  input  logic err,
  output logic trip
);

  localparam int unsigned WW = $clog2(WINDOW + 1);
  localparam int unsigned EW = $clog2(THRESHOLD + 1);

  logic [WW-1:0] win_q;
  logic [EW-1:0] ecnt_q;
  logic [EW-1:0] base;
  logic          wend;

  assign wend = (win_q == WW'(WINDOW - 1));
  assign base = wend ? '0 : ecnt_q;
  assign trip = err & ~clear &
                (base == EW'(THRESHOLD - 1));

  always_ff @(posedge WCLK) begin
    if (RESET || clear) begin
      win_q  <= '0;
      ecnt_q <= '0;
    end else begin
      win_q <= wend ? '0 : win_q + WW'(1);
      if (err)
        ecnt_q <= base + EW'(1);
      else if (wend)
        ecnt_q <= '0;
    end
  end

endmodule

// File: rtl/rx_link_ctrl.sv
// Receiver lane bring-up / supervision controller (WCLK domain).
// Trains via 8b10b record sync or raw phase scan; counts re-trains.
module rx_link_ctrl
  import rx_link_ctrl_pkg::*;
#(
  parameter int unsigned RESET_CYCLES    = 16,
  parameter int unsigned SYNC_TIMEOUT    = 4096,
  parameter int unsigned SYNC_HOLD       = 8,
  parameter int unsigned ERR_WINDOW      = 1024,
  parameter int unsigned ERR_THRESHOLD   = 8,
  parameter int unsigned PHASE_DWELL     = 64,
  parameter int unsigned PHASE_MATCH_MIN = 48
) (
  input  logic       WCLK,
  input  logic       RESET,
  input  logic       link_en,
  input  logic       no_8b10b_mode,
  input  logic       clr_cnt,
  input  logic       rec_sync_ready,
  input  logic       decoder_err,
  input  logic       raw_match,
  output logic       rx_reset,
  output logic       enable_rx,
  output logic [3:0] load_rawcnt,
  output logic       locked,
  output logic [2:0] state,
  output logic [7:0] resync_cnt
);

  localparam logic [15:0] RST_LAST = 16'(RESET_CYCLES - 1);
  localparam logic [15:0] TO_LAST  = 16'(SYNC_TIMEOUT - 1);
  localparam logic [15:0] HOLD_LST = 16'(SYNC_HOLD - 1);
  localparam logic [15:0] DW_LAST  = 16'(PHASE_DWELL - 1);
  localparam logic [15:0] MATCH_MN = 16'(PHASE_MATCH_MIN);

  link_st_e    state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic [15:0] run_q, run_d;
  logic [15:0] mcnt_q, mcnt_d;
  logic [15:0] tot;
  logic [3:0]  rej_q, rej_d;
  logic [3:0]  phase_q, phase_d;
  logic [7:0]  resync_q;
  logic        rx_reset_q;
  logic        en_q;
  logic        locked_q;
  logic        mode_q;
  logic        bump;
  logic        trip;
  logic        win_clr;

  assign win_clr = (state_q != ST_LOCKED) | mode_q;

  rx_link_err_window #(
    .WINDOW    (ERR_WINDOW),
    .THRESHOLD (ERR_THRESHOLD)
  ) u_err_win (
    .WCLK  (WCLK),
    .RESET (RESET),
    .clear (win_clr),
    .err   (decoder_err),
    .trip  (trip)
  );

  assign tot = mcnt_q + 16'(raw_match);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    run_d   = run_q;
    mcnt_d  = mcnt_q;
    rej_d   = rej_q;
    phase_d = phase_q;
    bump    = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (link_en) begin
          state_d = ST_RX_RST;
          cnt_d   = '0;
        end
      end
      ST_RX_RST: begin
        if (cnt_q == RST_LAST) begin
          cnt_d  = '0;
          run_d  = '0;
          mcnt_d = '0;
          rej_d  = '0;
          if (no_8b10b_mode) begin
            state_d = ST_SCAN;
            phase_d = '0;
          end else begin
            state_d = ST_WAIT_SYNC;
          end
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      ST_WAIT_SYNC: begin
        if (rec_sync_ready && run_q == HOLD_LST) begin
          state_d = ST_LOCKED;
          cnt_d   = '0;
        end else if (cnt_q == TO_LAST) begin
          state_d = ST_RX_RST;
          cnt_d   = '0;
          bump    = 1'b1;
        end else begin
          cnt_d = cnt_q + 16'd1;
          run_d = rec_sync_ready ? run_q + 16'd1 : '0;
        end
      end
      ST_SCAN: begin
        if (cnt_q == DW_LAST) begin
          cnt_d  = '0;
          mcnt_d = '0;
          if (tot >= MATCH_MN) begin
            state_d = ST_LOCKED;
          end else if (rej_q == PHASE_MAX) begin
            state_d = ST_RX_RST;
            bump    = 1'b1;
          end else begin
            rej_d   = rej_q + 4'd1;
            phase_d = next_phase(phase_q);
          end
        end else begin
          cnt_d  = cnt_q + 16'd1;
          mcnt_d = tot;
        end
      end
      ST_LOCKED: begin
        if (mode_q) begin
          if (raw_match) begin
            cnt_d = '0;
          end else if (cnt_q == TO_LAST) begin
            state_d = ST_RX_RST;
            cnt_d   = '0;
            bump    = 1'b1;
          end else begin
            cnt_d = cnt_q + 16'd1;
          end
        end else if (!rec_sync_ready || trip) begin
          state_d = ST_RX_RST;
          cnt_d   = '0;
          bump    = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    // Mode switch restarts training without counting as a re-train
    if (state_q != ST_IDLE && no_8b10b_mode != mode_q) begin
      state_d = ST_RX_RST;
      cnt_d   = '0;
      bump    = 1'b0;
    end
    if (!link_en) begin
      state_d = ST_IDLE;
      cnt_d   = '0;
      bump    = 1'b0;
    end
  end

  always_ff @(posedge WCLK) begin
    if (RESET) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      run_q      <= '0;
      mcnt_q     <= '0;
      rej_q      <= '0;
      phase_q    <= '0;
      resync_q   <= '0;
      rx_reset_q <= 1'b0;
      en_q       <= 1'b0;
      locked_q   <= 1'b0;
      mode_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      run_q      <= run_d;
      mcnt_q     <= mcnt_d;
      rej_q      <= rej_d;
      phase_q    <= phase_d;
      rx_reset_q <= (state_d == ST_RX_RST);
      en_q       <= (state_d == ST_LOCKED);
      locked_q   <= (state_d == ST_LOCKED);
      mode_q     <= no_8b10b_mode;
      if (clr_cnt)
        resync_q <= '0;
      else if (bump && resync_q != 8'hFF)
        resync_q <= resync_q + 8'd1;
    end
  end

  assign rx_reset    = rx_reset_q;
  assign enable_rx   = en_q;
  assign locked      = locked_q;
  assign load_rawcnt = phase_q;
  assign state       = state_q;
  assign resync_cnt  = resync_q;

endmodule

// File: tb/tb_rx_link_ctrl.sv
// Randomized scoreboard bench for rx_link_ctrl against a
// timestamp-based reference model of the link training rules.
module tb_rx_link_ctrl;

  localparam int RC   = 16;
  localparam int TO   = 128;
  localparam int HOLD = 8;
  localparam int W    = 128;
  localparam int THR  = 8;
  localparam int DW   = 64;
  localparam int MM   = 48;

  logic       WCLK = 1'b0;
  logic       RESET = 1'b1;
  logic       link_en = 1'b0;
  logic       no_8b10b_mode = 1'b0;
  logic       clr_cnt = 1'b0;
  logic       rec_sync_ready = 1'b0;
  logic       decoder_err = 1'b0;
  logic       raw_match = 1'b0;
  logic       rx_reset;
  logic       enable_rx;
  logic       locked;
  logic [3:0] load_rawcnt;
  logic [2:0] state;
  logic [7:0] resync_cnt;

  rx_link_ctrl #(
    .RESET_CYCLES    (RC),
    .SYNC_TIMEOUT    (TO),
    .SYNC_HOLD       (HOLD),
    .ERR_WINDOW      (W),
    .ERR_THRESHOLD   (THR),
    .PHASE_DWELL     (DW),
    .PHASE_MATCH_MIN (MM)
  ) dut (
    .WCLK           (WCLK),
    .RESET          (RESET),
    .link_en        (link_en),
    .no_8b10b_mode  (no_8b10b_mode),
    .clr_cnt        (clr_cnt),
    .rec_sync_ready (rec_sync_ready),
    .decoder_err    (decoder_err),
    .raw_match      (raw_match),
    .rx_reset       (rx_reset),
    .enable_rx      (enable_rx),
    .load_rawcnt    (load_rawcnt),
    .locked         (locked),
    .state          (state),
    .resync_cnt     (resync_cnt)
  );

  always #5 WCLK = ~WCLK;

  typedef struct {
    int st; bit rxr; bit en; bit lk;
    int phase; int rc; bit mprev;
    int t_ent; int t_low; int hits;
    int win; int werr; int t_match; bit inc;
  } ms_t;

  typedef struct {
    logic [2:0] st; logic rxr; logic en; logic lk;
    logic [3:0] ph; logic [7:0] rc;
  } exp_t;

  exp_t q[$];
  ms_t  m = '{default: 0};
  int   now = 0;
  int   vectors = 0;
  int   miscompares = 0;
  bit   done = 0;

  bit g_len, g_mode, g_rec;
  int g_errp, g_tgt, g_hit, g_miss;

  function automatic ms_t step(ms_t c, int t, bit rst, bit len,
                               bit mode, bit clr, bit rec,
                               bit err, bit rm);
    ms_t n;
    int  nx, k;
    bit  inc, ent;
    n = c; inc = 0; ent = 0; nx = c.st;
    k = t - c.t_ent;
    if (rst) begin
      n = '{default: 0};
      return n;
    end
    case (c.st)
      0: if (len) nx = 1;
      1: if (k >= RC) nx = mode ? 3 : 2;
      2: begin
        if (!rec) n.t_low = t;
        if (rec && t - c.t_low >= HOLD) nx = 4;
        else if (k >= TO) begin nx = 1; inc = 1; end
      end
      3: begin
        if (rm) n.hits = c.hits + 1;
        if (k % DW == 0) begin
          if (n.hits >= MM) nx = 4;
          else if (k / DW >= 10) begin nx = 1; inc = 1; end
          else n.phase = (c.phase + 1) % 10;
          n.hits = 0;
        end
      end
      4: begin
        if (mode) begin
          if (rm) n.t_match = t;
          else if (t - c.t_match >= TO) begin nx = 1; inc = 1; end
        end else if (!rec) begin
          nx = 1; inc = 1;
        end else if (err) begin
          if (k / W != c.win) begin n.win = k / W; n.werr = 0; end
          n.werr = n.werr + 1;
          if (n.werr >= THR) begin nx = 1; inc = 1; end
        end
      end
      default: nx = 0;
    endcase
    if (c.st != 0 && mode != c.mprev) begin
      nx = 1; inc = 0; ent = 1;
    end
    if (!len) begin nx = 0; inc = 0; end
    if (nx != c.st) ent = 1;
    if (ent) begin
      n.t_ent = t; n.t_low = t; n.hits = 0;
      n.win = 0; n.werr = 0; n.t_match = t;
      if (nx == 3) n.phase = 0;
    end
    n.st = nx; n.mprev = mode; n.inc = inc;
    if (clr) n.rc = 0;
    else if (inc && c.rc < 255) n.rc = c.rc + 1;
    n.rxr = (nx == 1);
    n.en  = (nx == 4);
    n.lk  = (nx == 4);
    return n;
  endfunction

  task automatic drive(input bit rst, input bit len, input bit mode,
                       input bit clr, input bit rec, input bit err);
    bit   rm;
    exp_t e;
    @(negedge WCLK);
    if (m.phase == g_tgt) rm = ($urandom_range(99) < g_hit);
    else                  rm = ($urandom_range(99) < g_miss);
    RESET = rst; link_en = len; no_8b10b_mode = mode;
    clr_cnt = clr; rec_sync_ready = rec;
    decoder_err = err; raw_match = rm;
    now++;
    m = step(m, now, rst, len, mode, clr, rec, err, rm);
    e.st = 3'(m.st); e.rxr = m.rxr; e.en = m.en; e.lk = m.lk;
    e.ph = 4'(m.phase); e.rc = 8'(m.rc);
    q.push_back(e);
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++)
      drive(0, g_len, g_mode, 0, g_rec,
            $urandom_range(999) < g_errp);
  endtask

  initial begin
    exp_t e;
    forever begin
      @(posedge WCLK);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        vectors++;
        if ({state, rx_reset, enable_rx, locked, load_rawcnt,
             resync_cnt} !== {e.st, e.rxr, e.en, e.lk, e.ph, e.rc})
        begin
          miscompares++;
          $display("FAIL status t=%0t: got st=%0d rxr=%0b en=%0b lk=%0b ph=%0d rc=%0d want st=%0d rxr=%0b en=%0b lk=%0b ph=%0d rc=%0d",
                   $time, state, rx_reset, enable_rx, locked,
                   load_rawcnt, resync_cnt, e.st, e.rxr, e.en,
                   e.lk, e.ph, e.rc);
        end
      end
    end
  end

  initial begin
    #5ms;
    if (!done) begin
      $display("FAIL timeout: stimulus did not finish, %0d vectors",
               vectors);
      $finish;
    end
  end

  initial begin
    bit  got;
    ms_t tr;
    g_len = 0; g_mode = 0; g_rec = 0; g_errp = 0;
    g_tgt = -1; g_hit = 0; g_miss = 0;
    repeat (4) drive(1, 0, 0, 0, 0, 0);
    @(posedge WCLK);
    #2;
    if (state !== 3'd0 || rx_reset !== 1'b0 ||
        enable_rx !== 1'b0 || locked !== 1'b0 ||
        load_rawcnt !== 4'd0 || resync_cnt !== 8'd0) begin
      miscompares++;
      $display("FAIL reset state: st=%0d rxr=%0b en=%0b lk=%0b ph=%0d rc=%0d",
               state, rx_reset, enable_rx, locked,
               load_rawcnt, resync_cnt);
    end
    run(3);

    g_len = 1;
    run(20);
    g_rec = 1;
    run(200);

    g_errp = 35;
    run(2500);
    g_errp = 300;
    run(150);
    g_errp = 0;
    run(100);
    drive(0, 1, 0, 1, 1, 0);

    g_rec = 0;
    run(260 * (RC + TO));

    got = 0;
    for (int i = 0; i < 400 && !got; i++) begin
      tr = step(m, now + 1, 0, 1, 0, 0, 0, 0, 0);
      if (tr.inc) begin
        drive(0, 1, 0, 1, 0, 0);
        got = 1;
      end else begin
        run(1);
      end
    end
    run(5);

    run(3);
    drive(0, 0, 0, 0, 0, 0);
    run(30);

    g_mode = 1; g_tgt = 6; g_hit = 95; g_miss = 3;
    run(800);
    g_hit = 0;
    run(300);
    g_tgt = -1; g_miss = 0;
    run(900);

    g_tgt = 3; g_hit = 90; g_miss = 5;
    run(100);
    drive(1, 1, 1, 0, 0, 0);
    drive(1, 1, 1, 0, 0, 0);
    run(400);

    g_mode = 0; g_rec = 1;
    run(100);

    for (int b = 0; b < 20; b++) begin
      g_mode = ($urandom_range(3) == 0);
      g_rec  = ($urandom_range(4) != 0);
      g_errp = $urandom_range(70);
      g_tgt  = $urandom_range(10);
      g_hit  = 60 + $urandom_range(40);
      g_miss = $urandom_range(10);
      for (int i = 0; i < 300; i++)
        drive(0, $urandom_range(399) != 0, g_mode,
              $urandom_range(299) == 0,
              g_rec && ($urandom_range(199) != 0),
              $urandom_range(999) < g_errp);
    end

    repeat (3) @(posedge WCLK);
    #2;
    done = 1;
    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    if (miscompares == 0) $display("PASS");
    else                  $display("FAIL");
    $finish;
  end

endmodule
